systolic_array_nxn: RTL and testbench



---
 rtl/systolic_pkg.sv | 27 ++
 rtl/systolic_array_nxn_if.sv | 41 ++++
 rtl/systolic_array_nxn_pe_acc.sv | 63 ++++++
 rtl/systolic_array_nxn.sv | 234 +++++++++++++++++++++++
 tb/tb_systolic_array_nxn.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// ----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the N x N output-stationary systolic array:
//   - state_t        : control FSM encoding (IDLE, LOAD, DRAIN, DONE)
//   - drain_steps()  : number of zero-injection steps needed to flush the skew
//   - step_cnt_bits(): width of a counter able to hold 0..max_steps
// ----------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Last operand needs (N-1) steps of row skew plus (N-1) of column skew
    // to reach the far corner PE.
    function automatic int unsigned drain_steps(input int unsigned n);
        return 2 * (n - 1);
    endfunction

    function automatic int unsigned step_cnt_bits(input int unsigned max_steps);
        return (max_steps < 1) ? 1 : $clog2(max_steps + 1);
    endfunction

endpackage

// File: rtl/systolic_array_nxn_if.sv
// ----------------------------------------------------------------------------
// systolic_array_nxn_if
// Job control, operand stream and result bus of the systolic array.
//   master : operand streamer / controller side (drives start, k_len, operands)
//   slave  : the array (drives in_ready, busy, done, result)
// Signals:
//   start    job start pulse          k_len    inner dimension of the job
//   in_valid operand beat valid       in_ready array accepts a beat (LOAD)
//   west_in  A column, row i slice    north_in B row, column j slice
//   busy     job in progress          done     one-cycle completion pulse
//   result   C(i,j) at [(i*N+j)*ACC_BIT +: ACC_BIT]
// ----------------------------------------------------------------------------
interface systolic_array_nxn_if #(
    parameter int unsigned N        = 4,
    parameter int unsigned DATA_BIT = 8,
    parameter int unsigned K_MAX    = 16,
    parameter int unsigned ACC_BIT  = 20
);
    localparam int unsigned KW = $clog2(K_MAX + 1);

    logic                      start;
    logic [KW-1:0]             k_len;
    logic                      in_valid;
    logic                      in_ready;
    logic [N*DATA_BIT-1:0]     west_in;
    logic [N*DATA_BIT-1:0]     north_in;
    logic                      busy;
    logic                      done;
    logic [N*N*ACC_BIT-1:0]    result;

    modport master (
        output start, k_len, in_valid, west_in, north_in,
        input  in_ready, busy, done, result
    );

    modport slave (
        input  start, k_len, in_valid, west_in, north_in,
        output in_ready, busy, done, result
    );

endinterface

// File: rtl/systolic_array_nxn_pe_acc.sv
// ----------------------------------------------------------------------------
// pe_acc
// One processing element of the output-stationary array.
// On i_en: acc += i_west * i_north, and the operands are registered onward
// (west -> o_east, north -> o_south). i_clr zeroes everything synchronously.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_en              global advance enable
//   i_clr             synchronous clear (new job)
//   i_west, i_north   operands arriving from the neighbour / skew line
//   o_east, o_south   registered operands passed to the neighbours
//   o_acc             accumulator
// Build option: SYSTOLIC_SIGNED_EN selects two's-complement operands with a
// sign-extended product; otherwise operands are unsigned and zero-extended.
// Accumulation wraps modulo 2^ACC_BIT in both builds.
// ----------------------------------------------------------------------------
module pe_acc #(
    parameter int unsigned DATA_BIT = 8,
    parameter int unsigned ACC_BIT  = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic                i_clr,
    input  logic [DATA_BIT-1:0] i_west,
    input  logic [DATA_BIT-1:0] i_north,
    output logic [DATA_BIT-1:0] o_east,
    output logic [DATA_BIT-1:0] o_south,
    output logic [ACC_BIT-1:0]  o_acc
);

    logic [DATA_BIT-1:0] r_east;
    logic [DATA_BIT-1:0] r_south;
    logic [ACC_BIT-1:0]  r_acc;
    logic [ACC_BIT-1:0]  w_prod_ext;

`ifdef SYSTOLIC_SIGNED_EN
    logic signed [2*DATA_BIT-1:0] w_prod;
    assign w_prod     = $signed(i_west) * $signed(i_north);
    assign w_prod_ext = ACC_BIT'(w_prod);
`else
    logic [2*DATA_BIT-1:0] w_prod;
    assign w_prod     = i_west * i_north;
    assign w_prod_ext = ACC_BIT'(w_prod);
`endif

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_east  <= '0;
            r_south <= '0;
            r_acc   <= '0;
        end else if (i_en) begin
            r_east  <= i_west;
            r_south <= i_north;
            r_acc   <= r_acc + w_prod_ext;
        end
    end

    assign o_east  = r_east;
    assign o_south = r_south;
    assign o_acc   = r_acc;

endmodule

// File: rtl/systolic_array_nxn.sv
// ----------------------------------------------------------------------------
// systolic_array_nxn
// N x N output-stationary systolic matrix multiplier, C = A x B.
// Each accepted beat carries one column of A (west_in) and one row of B
// (north_in). Row i of A is skewed by i steps, column j of B by j steps, so
// element k meets in PE(i,j) on advance step k+i+j. After k_eff beats the
// array is flushed with zeros for 2*(N-1) steps, then done pulses once.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset (aborts any job, no done)
//   bus  systolic_array_nxn_if.slave: start/k_len, in_valid/in_ready,
//        west_in/north_in, busy, done, result
// Build option: SYSTOLIC_SIGNED_EN (signed MAC, see pe_acc).
// ----------------------------------------------------------------------------
module systolic_array_nxn
    import systolic_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned DATA_BIT = 8,
    parameter int unsigned K_MAX    = 16,
    parameter int unsigned ACC_BIT  = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_array_nxn_if.slave  bus
);

    localparam int unsigned KW          = $clog2(K_MAX + 1);
    localparam int unsigned DRAIN_STEPS = drain_steps(N);
    localparam int unsigned CW          =
        step_cnt_bits((K_MAX > DRAIN_STEPS) ? K_MAX : DRAIN_STEPS);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [KW-1:0]   r_keff;
    logic [CW-1:0]   r_cnt;
    logic [KW-1:0]   w_klen_clamp;
    logic            w_in_ready;
    logic            w_busy;
    logic            w_done;
    logic            w_accept;
    logic            w_adv;
    logic            w_clr;
    logic            w_last_beat;
    logic            w_last_drain;

    assign w_klen_clamp = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
    assign w_accept     = w_in_ready & bus.in_valid;
    assign w_adv        = w_accept | (r_state == ST_DRAIN);
    assign w_clr        = (r_state == ST_IDLE) & bus.start;
    assign w_last_beat  = ((r_cnt + CW'(1)) == CW'(r_keff));
    assign w_last_drain = (r_cnt == CW'(DRAIN_STEPS - 1));

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (w_klen_clamp == '0) ? ST_DRAIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept && w_last_beat) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_drain) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            ST_DRAIN: begin
                w_busy     = 1'b1;
            end
            ST_DONE: begin
                w_done     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.in_ready = w_in_ready;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;

    // ---------------- step counter / job length ----------------
    // One counter serves both phases: beats accepted in LOAD, steps in DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_keff <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (bus.start) begin
                        r_keff <= w_klen_clamp;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_cnt <= w_last_beat ? '0 : r_cnt + CW'(1);
                    end
                end
                ST_DRAIN: begin
                    r_cnt <= w_last_drain ? '0 : r_cnt + CW'(1);
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // ---------------- input skew ----------------
    logic [DATA_BIT-1:0] w_west_src  [N];
    logic [DATA_BIT-1:0] w_north_src [N];
    logic [DATA_BIT-1:0] w_west_sk   [N];
    logic [DATA_BIT-1:0] w_north_sk  [N];

    for (genvar g = 0; g < N; g++) begin : g_skew
        // Zeros are injected outside LOAD so DRAIN flushes the array cleanly.
        assign w_west_src[g]  = (r_state == ST_LOAD) ?
                                bus.west_in[g*DATA_BIT +: DATA_BIT]  : '0;
        assign w_north_src[g] = (r_state == ST_LOAD) ?
                                bus.north_in[g*DATA_BIT +: DATA_BIT] : '0;

        if (g == 0) begin : g_direct
            assign w_west_sk[g]  = w_west_src[g];
            assign w_north_sk[g] = w_north_src[g];
        end else begin : g_delay
            logic [DATA_BIT-1:0] r_wsr [g];
            logic [DATA_BIT-1:0] r_nsr [g];

            always_ff @(posedge clk) begin
                if (rst || w_clr) begin
                    for (int unsigned k = 0; k < g; k++) begin
                        r_wsr[k] <= '0;
                        r_nsr[k] <= '0;
                    end
                end else if (w_adv) begin
                    r_wsr[0] <= w_west_src[g];
                    r_nsr[0] <= w_north_src[g];
                    for (int unsigned k = 1; k < g; k++) begin
                        r_wsr[k] <= r_wsr[k-1];
                        r_nsr[k] <= r_nsr[k-1];
                    end
                end
            end

            assign w_west_sk[g]  = r_wsr[g-1];
            assign w_north_sk[g] = r_nsr[g-1];
        end
    end

    // ---------------- PE grid ----------------
    logic [DATA_BIT-1:0] w_east  [N][N];
    logic [DATA_BIT-1:0] w_south [N][N];
    logic [ACC_BIT-1:0]  w_acc   [N][N];

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic [DATA_BIT-1:0] w_pe_west;
            logic [DATA_BIT-1:0] w_pe_north;

            if (c == 0) begin : g_wedge
                assign w_pe_west = w_west_sk[r];
            end else begin : g_winner
                assign w_pe_west = w_east[r][c-1];
            end

            if (r == 0) begin : g_nedge
                assign w_pe_north = w_north_sk[c];
            end else begin : g_ninner
                assign w_pe_north = w_south[r-1][c];
            end

            pe_acc #(
                .DATA_BIT (DATA_BIT),
                .ACC_BIT  (ACC_BIT)
            ) u_pe (
                .clk     (clk),
                .rst     (rst),
                .i_en    (w_adv),
                .i_clr   (w_clr),
                .i_west  (w_pe_west),
                .i_north (w_pe_north),
                .o_east  (w_east[r][c]),
                .o_south (w_south[r][c]),
                .o_acc   (w_acc[r][c])
            );

            assign bus.result[(r*N+c)*ACC_BIT +: ACC_BIT] = w_acc[r][c];
        end
    end

    // East/south pass registers of the last column/row leave the array.
    logic w_unused_edge;
    always_comb begin
        w_unused_edge = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            w_unused_edge = w_unused_edge ^ (^w_east[k][N-1]) ^ (^w_south[N-1][k]);
        end
    end

endmodule

// File: tb/tb_systolic_array_nxn.sv
module tb_systolic_array_nxn;

    localparam int N    = 4;
    localparam int DB   = 8;
    localparam int KM   = 16;
    localparam int KW   = $clog2(KM + 1);
    localparam int AB   = 20;
    localparam int AB16 = 16;

    logic   clk = 1'b0;
    logic   rst;
    longint cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_array_nxn_if #(.N(N), .DATA_BIT(DB), .K_MAX(KM), .ACC_BIT(AB))   bus();
    systolic_array_nxn_if #(.N(N), .DATA_BIT(DB), .K_MAX(KM), .ACC_BIT(AB16)) bus16();

    assign bus16.start    = bus.start;
    assign bus16.k_len    = bus.k_len;
    assign bus16.in_valid = bus.in_valid;
    assign bus16.west_in  = bus.west_in;
    assign bus16.north_in = bus.north_in;

    systolic_array_nxn #(.N(N), .DATA_BIT(DB), .K_MAX(KM), .ACC_BIT(AB)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    systolic_array_nxn #(.N(N), .DATA_BIT(DB), .K_MAX(KM), .ACC_BIT(AB16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    typedef struct {
        longint                done_cyc;
        logic [N*N*AB-1:0]     c20;
        logic [N*N*AB16-1:0]   c16;
    } exp_t;

    exp_t sb[$];

    int unsigned A [N][KM];
    int unsigned B [KM][N];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic longint mul_model(input int unsigned a, input int unsigned b);
        longint sa;
        longint sbv;
`ifdef SYSTOLIC_SIGNED_EN
        sa  = (a >= (1 << (DB-1))) ? longint'(a) - longint'(1 << DB) : longint'(a);
        sbv = (b >= (1 << (DB-1))) ? longint'(b) - longint'(1 << DB) : longint'(b);
`else
        sa  = longint'(a);
        sbv = longint'(b);
`endif
        return sa * sbv;
    endfunction

    task automatic fill(input int unsigned av, input int unsigned bv);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < KM; k++) begin
                A[i][k] = av;
                B[k][i] = bv;
            end
    endtask

    // Scoreboard: each entry is checked when the DUT pulses done.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.done_cyc);
                check("done16_align", bus16.done, 1);
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        check($sformatf("c20[%0d][%0d]", i, j),
                              64'(bus.result[(i*N+j)*AB +: AB]), 64'(e.c20[(i*N+j)*AB +: AB]));
                        check($sformatf("c16[%0d][%0d]", i, j),
                              64'(bus16.result[(i*N+j)*AB16 +: AB16]), 64'(e.c16[(i*N+j)*AB16 +: AB16]));
                    end
            end
        end
    end

    task automatic drive_beat(input int b);
        for (int i = 0; i < N; i++) begin
            bus.west_in[i*DB +: DB]  = DB'(A[i][b]);
            bus.north_in[i*DB +: DB] = DB'(B[b][i]);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE
    // cycle after done, so a following call starts back-to-back.
    task automatic run_job(input int klen, input bit stall, input bit junk);
        int     keff;
        int     nst;
        int     t;
        longint sum;
        exp_t   e;
        keff = (klen > KM) ? KM : klen;
        nst  = stall ? keff : 0;
        e.done_cyc = cyc + 1 + keff + 2*(N-1) + nst;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                sum = 0;
                for (int k = 0; k < keff; k++) sum += mul_model(A[i][k], B[k][j]);
                e.c20[(i*N+j)*AB +: AB]     = AB'(sum);
                e.c16[(i*N+j)*AB16 +: AB16] = AB16'(sum);
            end
        sb.push_back(e);

        bus.k_len = KW'(klen);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int b = 0; b < keff; b++) begin
            if (stall) begin
                bus.in_valid = 1'b0;
                bus.west_in  = $urandom;
                bus.north_in = $urandom;
                if (junk) bus.start = 1'b1;
                check("ready_stall", bus.in_ready, 1);
                @(negedge clk);
                bus.start = 1'b0;
            end
            bus.in_valid = 1'b1;
            drive_beat(b);
            check("ready_beat", bus.in_ready, 1);
            check("busy_beat", bus.busy, 1);
            @(negedge clk);
        end
        bus.in_valid = junk;
        bus.west_in  = junk ? $urandom : '0;
        bus.north_in = junk ? $urandom : '0;
        t = 0;
        while (!bus.done && t < 200) begin
            check("busy_drain", bus.busy, 1);
            @(negedge clk);
            t++;
        end
        if (!bus.done) check("done_timeout", 0, 1);
        bus.in_valid = 1'b0;
        check("ready_at_done", bus.in_ready, 0);
        @(negedge clk);
        check("busy_idle", bus.busy, 0);
    endtask

    initial begin
        bit seen;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.k_len    = '0;
        bus.in_valid = 1'b0;
        bus.west_in  = '0;
        bus.north_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.in_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", 64'(|bus.result), 0);
        check("rst_result16", 64'(|bus16.result), 0);

        // Identity A, B(k,j) = 4k+j+1
        fill(0, 0);
        for (int i = 0; i < N; i++) A[i][i] = 1;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++) B[k][j] = 4*k + j + 1;
        run_job(4, 1'b0, 1'b0);
        // Same data with stalls, ignored start in LOAD, junk valid in DRAIN
        run_job(4, 1'b1, 1'b1);

        // Full scale, wraps in the 16-bit instance
        fill(255, 255);
        run_job(16, 1'b0, 1'b0);

        // k_len above K_MAX is clamped
        fill(1, 1);
        run_job(31, 1'b0, 1'b0);

        // Back-to-back jobs
        fill(1, 1);
        run_job(3, 1'b0, 1'b0);
        fill(2, 2);
        run_job(2, 1'b0, 1'b0);

        // Empty job
        run_job(0, 1'b0, 1'b1);

        // Abort during LOAD beat 2
        fill(1, 1);
        bus.k_len = KW'(4);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus.in_valid = 1'b1;
            drive_beat(b);
            if (b == 2) rst = 1'b1;
            @(negedge clk);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("abort_ready", bus.in_ready, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_result", 64'(|bus.result), 0);
        check("abort_result16", 64'(|bus16.result), 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        run_job(3, 1'b0, 1'b0);

        // Signedness probe: 0xFF x 0x02 over K=4
        fill(8'hFF, 8'h02);
        run_job(4, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
